// File: rtl/ee354_project_direction_pkg.sv
// ee354_project_direction_pkg: direction codes, tick default and reversal helper for the Snake input stage
package ee354_project_direction_pkg;
  typedef enum logic [1:0] {DIR_UP = 2'd0, DIR_DOWN = 2'd1, DIR_LEFT = 2'd2, DIR_RIGHT = 2'd3} dir_e;
  localparam int TICK_DIV_DEFAULT = 25_000_000;
  function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction
endpackage

// File: rtl/ee354_project_direction_if.sv
// ee354_project_direction_if: buttons, game state and direction/strobe outputs of the input stage
interface ee354_project_direction_if;
  logic BtnU, BtnD, BtnL, BtnR;
  logic q_I, q_Run, q_Win, q_Lose;
  logic [1:0] In_Dirn;
  logic SCEN;
  logic [1:0] Queue_Count;
  logic Turn_Dropped;
  modport master (output BtnU, BtnD, BtnL, BtnR, q_I, q_Run, q_Win, q_Lose,
                  input In_Dirn, SCEN, Queue_Count, Turn_Dropped);
  modport slave (input BtnU, BtnD, BtnL, BtnR, q_I, q_Run, q_Win, q_Lose,
                 output In_Dirn, SCEN, Queue_Count, Turn_Dropped);
endinterface

// File: rtl/ee354_project_turn_fifo.sv
// ee354_project_turn_fifo: 2-deep 2-bit turn queue with simultaneous push/pop and clear
module ee354_project_turn_fifo (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic       clear_i,
  input  logic [1:0] din_i,
  output logic [1:0] head_o,
  output logic [1:0] tail_o,
  output logic [1:0] count_o
);
  logic [1:0][1:0] mem_q, mem_d;
  logic [1:0] cnt_q, cnt_d, c1;
  logic pop;
  assign pop = pop_i && cnt_q != 2'd0;
  // occupancy after the pop; the push then lands in the first free slot
  assign c1 = cnt_q - {1'b0, pop};
  always_comb begin
    mem_d = pop ? {mem_q[1], mem_q[1]} : mem_q;
    cnt_d = c1;
    if (push_i && c1 != 2'd2) begin
      mem_d[c1[0]] = din_i;
      cnt_d = c1 + 2'd1;
    end
    if (clear_i) cnt_d = 2'd0;
  end
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      mem_q <= '0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end
  assign head_o = mem_q[0];
  assign tail_o = cnt_q == 2'd2 ? mem_q[1] : mem_q[0];
  assign count_o = cnt_q;
endmodule

// File: rtl/ee354_project_direction.sv
// ee354_project_direction: button edge detect, turn validation/queueing and periodic SCEN move strobe
module ee354_project_direction
  import ee354_project_direction_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT,
  parameter int TICK_W = 25
) (
  input logic Clk,
  input logic Reset,
  ee354_project_direction_if.slave io
);
  logic [3:0] btn_q, btns, rise;
  logic [1:0] dirn_q, dirn_d, sel, ref_dir, f_head, f_tail, f_cnt;
  logic [TICK_W-1:0] cnt_q, cnt_d;
  logic scen_q, drop_q, drop_d;
  logic any, same, rev, ok, active, tick, pop, push, full;
  assign btns = {io.BtnU, io.BtnD, io.BtnL, io.BtnR};
  assign rise = btns & ~btn_q;
  assign any = |rise;
  assign sel = rise[3] ? DIR_UP : rise[2] ? DIR_DOWN : rise[1] ? DIR_LEFT : DIR_RIGHT;
  // new turns are judged against the last queued turn, not the current heading
  assign ref_dir = f_cnt != 2'd0 ? f_tail : dirn_q;
  assign same = sel == ref_dir;
  assign rev = is_reverse(sel, ref_dir);
  assign active = !(io.q_Win || io.q_Lose) && (io.q_I || io.q_Run);
  assign ok = active && any && !same && !rev;
  assign full = f_cnt == 2'd2;
  assign tick = io.q_Run && cnt_q == TICK_W'(TICK_DIV - 2);
  assign pop = tick && f_cnt != 2'd0;
  assign push = io.q_Run && ok && (!full || pop);
  assign drop_d = active && any && !same && (rev || (io.q_Run && full && !pop));
  assign dirn_d = pop ? f_head : (io.q_I && ok) ? sel : dirn_q;
  assign cnt_d = !io.q_Run ? '0 : cnt_q == TICK_W'(TICK_DIV - 1) ? '0 : cnt_q + TICK_W'(1);
  ee354_project_turn_fifo u_fifo (
    .Clk(Clk), .Reset(Reset), .push_i(push), .pop_i(pop), .clear_i(!io.q_Run),
    .din_i(sel), .head_o(f_head), .tail_o(f_tail), .count_o(f_cnt)
  );
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      btn_q <= '0;
      dirn_q <= DIR_UP;
      cnt_q <= '0;
      scen_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      btn_q <= btns;
      dirn_q <= dirn_d;
      cnt_q <= cnt_d;
      scen_q <= tick;
      drop_q <= drop_d;
    end
  end
  assign io.In_Dirn = dirn_q;
  assign io.SCEN = scen_q;
  assign io.Queue_Count = f_cnt;
  assign io.Turn_Dropped = drop_q;
endmodule

// File: tb/tb_ee354_project_direction.sv
// tb_ee354_project_direction: directed checks of the Snake direction stage with TICK_DIV=8
module tb_ee354_project_direction;
  logic Clk, Reset;
  int checks = 0;
  int fails = 0;
  int k = 0;
  ee354_project_direction_if io();
  ee354_project_direction #(.TICK_DIV(8), .TICK_W(4)) dut (.Clk(Clk), .Reset(Reset), .io(io.slave));
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    k = (!Reset || !io.q_Run) ? 0 : (k + 1) % 8;
    #1;
  endtask

  task automatic advance_to(input int c);
    for (int g = 0; g < 16 && k != c; g++) step();
    checks++;
    if (k != c) begin fails++; $display("FAIL advance_to got=%0d exp=%0d", k, c); end
  endtask

  task automatic set_btns(input logic [3:0] b);
    {io.BtnU, io.BtnD, io.BtnL, io.BtnR} = b;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    set_btns(4'b0000);
    {io.q_I, io.q_Run, io.q_Win, io.q_Lose} = 4'b0000;
    step(); step();
    Reset = 1'b1;
    checks++; if (io.In_Dirn !== 2'b00) begin fails++; $display("FAIL reset_dirn got=%b exp=00", io.In_Dirn); end
    checks++; if (io.SCEN !== 1'b0) begin fails++; $display("FAIL reset_scen got=%b exp=0", io.SCEN); end
    checks++; if (io.Queue_Count !== 2'd0) begin fails++; $display("FAIL reset_qc got=%0d exp=0", io.Queue_Count); end
    checks++; if (io.Turn_Dropped !== 1'b0) begin fails++; $display("FAIL reset_td got=%b exp=0", io.Turn_Dropped); end
  endtask

  task automatic test_scen_period();
    io.q_Run = 1'b1;
    for (int e = 0; e < 24; e++) begin
      step();
      checks++;
      if (io.SCEN !== 1'(e % 8 == 6)) begin
        fails++; $display("FAIL scen_period edge=%0d got=%b exp=%b", e, io.SCEN, e % 8 == 6);
      end
    end
    checks++; if (io.In_Dirn !== 2'b00) begin fails++; $display("FAIL period_dirn got=%b exp=00", io.In_Dirn); end
    checks++; if (io.Queue_Count !== 2'd0) begin fails++; $display("FAIL period_qc got=%0d exp=0", io.Queue_Count); end
  endtask

  task automatic test_reversal();
    set_btns(4'b0100);
    step();
    checks++; if (io.Turn_Dropped !== 1'b1) begin fails++; $display("FAIL rev_td got=%b exp=1", io.Turn_Dropped); end
    checks++; if (io.Queue_Count !== 2'd0) begin fails++; $display("FAIL rev_qc got=%0d exp=0", io.Queue_Count); end
    set_btns(4'b0000);
    step();
    checks++; if (io.Turn_Dropped !== 1'b0) begin fails++; $display("FAIL rev_td_once got=%b exp=0", io.Turn_Dropped); end
    set_btns(4'b1000);
    step();
    checks++; if (io.Turn_Dropped !== 1'b0) begin fails++; $display("FAIL same_td got=%b exp=0", io.Turn_Dropped); end
    checks++; if (io.Queue_Count !== 2'd0) begin fails++; $display("FAIL same_qc got=%0d exp=0", io.Queue_Count); end
    set_btns(4'b0000);
    step();
  endtask

  task automatic test_queue_fill();
    int td_seen = 0;
    advance_to(1);
    set_btns(4'b0001);
    step();
    td_seen += int'(io.Turn_Dropped);
    checks++; if (io.Queue_Count !== 2'd1) begin fails++; $display("FAIL fill_qc1 got=%0d exp=1", io.Queue_Count); end
    set_btns(4'b0000);
    step();
    td_seen += int'(io.Turn_Dropped);
    set_btns(4'b0100);
    step();
    td_seen += int'(io.Turn_Dropped);
    checks++; if (io.Queue_Count !== 2'd2) begin fails++; $display("FAIL fill_qc2 got=%0d exp=2", io.Queue_Count); end
    set_btns(4'b0000);
    while (k != 7) begin step(); td_seen += int'(io.Turn_Dropped); end
    checks++; if (io.SCEN !== 1'b1) begin fails++; $display("FAIL fill_scen1 got=%b exp=1", io.SCEN); end
    checks++; if (io.In_Dirn !== 2'b11) begin fails++; $display("FAIL fill_dirn1 got=%b exp=11", io.In_Dirn); end
    checks++; if (io.Queue_Count !== 2'd1) begin fails++; $display("FAIL fill_pop1 got=%0d exp=1", io.Queue_Count); end
    for (int i = 0; i < 8; i++) begin step(); td_seen += int'(io.Turn_Dropped); end
    checks++; if (io.SCEN !== 1'b1) begin fails++; $display("FAIL fill_scen2 got=%b exp=1", io.SCEN); end
    checks++; if (io.In_Dirn !== 2'b01) begin fails++; $display("FAIL fill_dirn2 got=%b exp=01", io.In_Dirn); end
    checks++; if (io.Queue_Count !== 2'd0) begin fails++; $display("FAIL fill_pop2 got=%0d exp=0", io.Queue_Count); end
    checks++; if (td_seen != 0) begin fails++; $display("FAIL fill_td_pulses got=%0d exp=0", td_seen); end
  endtask

  task automatic test_full_drop();
    set_btns(4'b0010);
    step();
    checks++; if (io.Queue_Count !== 2'd1) begin fails++; $display("FAIL full_qc1 got=%0d exp=1", io.Queue_Count); end
    set_btns(4'b1000);
    step();
    checks++; if (io.Queue_Count !== 2'd2) begin fails++; $display("FAIL full_qc2 got=%0d exp=2", io.Queue_Count); end
    set_btns(4'b0000);
    advance_to(2);
    set_btns(4'b0001);
    step();
    checks++; if (io.Turn_Dropped !== 1'b1) begin fails++; $display("FAIL full_td got=%b exp=1", io.Turn_Dropped); end
    checks++; if (io.Queue_Count !== 2'd2) begin fails++; $display("FAIL full_qc_hold got=%0d exp=2", io.Queue_Count); end
    set_btns(4'b0000);
    advance_to(6);
    set_btns(4'b0001);
    step();
    checks++; if (io.SCEN !== 1'b1) begin fails++; $display("FAIL pp_scen got=%b exp=1", io.SCEN); end
    checks++; if (io.Turn_Dropped !== 1'b0) begin fails++; $display("FAIL pp_td got=%b exp=0", io.Turn_Dropped); end
    checks++; if (io.Queue_Count !== 2'd2) begin fails++; $display("FAIL pp_qc got=%0d exp=2", io.Queue_Count); end
    checks++; if (io.In_Dirn !== 2'b10) begin fails++; $display("FAIL pp_dirn got=%b exp=10", io.In_Dirn); end
    set_btns(4'b0000);
    for (int i = 0; i < 8; i++) step();
    checks++; if (io.In_Dirn !== 2'b00 || io.Queue_Count !== 2'd1) begin
      fails++; $display("FAIL pp_next1 got=%b/%0d exp=00/1", io.In_Dirn, io.Queue_Count); end
    for (int i = 0; i < 8; i++) step();
    checks++; if (io.In_Dirn !== 2'b11 || io.Queue_Count !== 2'd0) begin
      fails++; $display("FAIL pp_next2 got=%b/%0d exp=11/0", io.In_Dirn, io.Queue_Count); end
  endtask

  task automatic test_priority_idle();
    int scen_seen = 0;
    io.q_Run = 1'b0;
    io.q_I = 1'b1;
    step();
    scen_seen += int'(io.SCEN);
    set_btns(4'b1010);
    step();
    scen_seen += int'(io.SCEN);
    checks++; if (io.In_Dirn !== 2'b00) begin fails++; $display("FAIL prio_ul got=%b exp=00", io.In_Dirn); end
    checks++; if (io.Turn_Dropped !== 1'b0) begin fails++; $display("FAIL prio_td got=%b exp=0", io.Turn_Dropped); end
    set_btns(4'b0000);
    step();
    scen_seen += int'(io.SCEN);
    set_btns(4'b0011);
    step();
    scen_seen += int'(io.SCEN);
    checks++; if (io.In_Dirn !== 2'b10) begin fails++; $display("FAIL prio_lr got=%b exp=10", io.In_Dirn); end
    checks++; if (io.Queue_Count !== 2'd0) begin fails++; $display("FAIL idle_qc got=%0d exp=0", io.Queue_Count); end
    set_btns(4'b0000);
    for (int i = 0; i < 10; i++) begin step(); scen_seen += int'(io.SCEN); end
    checks++; if (scen_seen != 0) begin fails++; $display("FAIL idle_scen got=%0d exp=0", scen_seen); end
  endtask

  task automatic test_reset_mid_and_lose();
    int scen_seen = 0;
    io.q_I = 1'b0;
    io.q_Run = 1'b1;
    step();
    set_btns(4'b1000);
    step();
    checks++; if (io.Queue_Count !== 2'd1) begin fails++; $display("FAIL mid_push got=%0d exp=1", io.Queue_Count); end
    set_btns(4'b0000);
    advance_to(5);
    Reset = 1'b0;
    step();
    Reset = 1'b1;
    checks++; if (io.In_Dirn !== 2'b00) begin fails++; $display("FAIL mid_dirn got=%b exp=00", io.In_Dirn); end
    checks++; if (io.Queue_Count !== 2'd0) begin fails++; $display("FAIL mid_qc got=%0d exp=0", io.Queue_Count); end
    checks++; if (io.SCEN !== 1'b0) begin fails++; $display("FAIL mid_scen got=%b exp=0", io.SCEN); end
    for (int e = 0; e < 7; e++) begin
      step();
      checks++;
      if (io.SCEN !== 1'(e == 6)) begin fails++; $display("FAIL mid_restart edge=%0d got=%b exp=%b", e, io.SCEN, e == 6); end
    end
    io.q_Run = 1'b0;
    io.q_Lose = 1'b1;
    step();
    set_btns(4'b0001);
    step();
    scen_seen += int'(io.SCEN);
    checks++; if (io.In_Dirn !== 2'b00 || io.Queue_Count !== 2'd0) begin
      fails++; $display("FAIL lose_press got=%b/%0d exp=00/0", io.In_Dirn, io.Queue_Count); end
    set_btns(4'b0000);
    step();
    set_btns(4'b0100);
    step();
    scen_seen += int'(io.SCEN);
    checks++; if (io.Turn_Dropped !== 1'b0) begin fails++; $display("FAIL lose_td got=%b exp=0", io.Turn_Dropped); end
    set_btns(4'b0000);
    for (int i = 0; i < 10; i++) begin step(); scen_seen += int'(io.SCEN); end
    checks++; if (scen_seen != 0) begin fails++; $display("FAIL lose_scen got=%0d exp=0", scen_seen); end
  endtask

  initial begin
    test_reset();
    test_scen_period();
    test_reversal();
    test_queue_fill();
    test_full_drop();
    test_priority_idle();
    test_reset_mid_and_lose();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/ee354_project_direction.md
# ee354_project_direction

Upstream input stage for the Snake DPU: converts the four push-button levels into the 2-bit `In_Dirn` code and generates the single-cycle `SCEN` move strobe that advances the snake-length/position stage. Buffers up to two pending turns so quick successive presses are not lost between moves. Rejects 180° reversals and no-op turns. Sits between the debounced button inputs and the length/position stage and apple stage.

## Interface
Parameters:
- `TICK_DIV`, default 25_000_000: clock cycles per move (4 moves/s at 100 MHz); legal range ≥ 4.
- `TICK_W`, default 25: counter width, ≥ clog2(`TICK_DIV`).

Ports:
- `Clk` in 1: system clock; the only clock.
- `Reset` in 1: reset, synchronous and active-low.
- `BtnU`, `BtnD`, `BtnL`, `BtnR` in 1 each: debounced button levels.
- `q_I`, `q_Run`, `q_Win`, `q_Lose` in 1 each: one-hot game state from the controller.
- `In_Dirn` out 2: current direction (00 up, 01 down, 10 left, 11 right).
- `SCEN` out 1: one-cycle move strobe.
- `Queue_Count` out 2: pending turns (0–2).
- `Turn_Dropped` out 1: one-cycle pulse when a press is rejected for reversal or a full queue.

## Operation
- Reset (`Reset`=0 at posedge) sets `In_Dirn`=00, `SCEN`=0, `Queue_Count`=0, `Turn_Dropped`=0, tick counter=0, and button history=0. Reset mid-move discards the queue and the partial count.
- Press = rising edge of a button level, detected against the previous-cycle sample. If several buttons rise in the same cycle, only one press is accepted, with priority U > D > L > R; the others are discarded silently.
- Reference direction for checks:
  - tail of the queue if `Queue_Count` > 0;
  - else `In_Dirn`.
- Press equal to the reference direction: ignored; no push and no `Turn_Dropped`.
- Reversal means same bit[1] and different bit[0] as the reference. A reversal press is dropped and pulses `Turn_Dropped`.
- `q_I`: a valid press writes `In_Dirn` directly at the next edge. The queue is held empty, the counter is held at 0, and `SCEN`=0.
- `q_Run`:
  - A valid press pushes to the queue.
  - If the queue is full and no pop occurs in the same cycle, the press is dropped and pulses `Turn_Dropped`.
  - A push and a pop in the same cycle are both performed; the count is unchanged, including at count 2.
- `q_Win` / `q_Lose`:
  - Presses are ignored.
  - The queue is cleared.
  - The counter is held at 0 and `SCEN`=0.
  - `In_Dirn` is held.
- Arithmetic: the counter wraps from `TICK_DIV`-1 to 0. There is no other arithmetic.

## Timing
- The tick counter runs only while `q_Run`=1, counting 0 … `TICK_DIV`-1.
- At the edge where the counter equals `TICK_DIV`-2:
  - `SCEN` is registered to 1;
  - if the queue is non-empty, `In_Dirn` takes the queue head and the head is popped.
  - `In_Dirn` is therefore stable for the whole `SCEN`-high cycle, and the downstream stage samples the new direction.
- `SCEN` is high exactly one cycle per `TICK_DIV` cycles.
- The first `SCEN` after entering `q_Run` arrives at cycle `TICK_DIV`-1 counted from the entry edge.
- Press-to-queue latency: 1 cycle from the level rising to the `Queue_Count` update.
- Press-to-`In_Dirn` latency in `q_I`: 1 cycle.
- `Turn_Dropped` is registered and asserts 1 cycle after the offending level rise.
- Leaving `q_Run`: `SCEN` is forced to 0 at the next edge, even mid-period.

## Structure
- Shared package constants:
  - `DIR_UP`=2'd0, `DIR_DOWN`=2'd1, `DIR_LEFT`=2'd2, `DIR_RIGHT`=2'd3;
  - an `is_reverse(a,b)` helper;
  - `TICK_DIV` default.
- One sub-module, `ee354_project_turn_fifo`:
  - 2-deep, 2-bit-wide synchronous FIFO;
  - push/pop/clear inputs;
  - head, tail and count outputs;
  - simultaneous push and pop allowed.
- The top block holds the edge detect, priority select, validity check, tick counter and `In_Dirn`/`SCEN` registers.

## Test plan
- Use `TICK_DIV`=8. Reset, then assert `q_Run`. Required: `In_Dirn`=00; `SCEN` high at cycles 7, 15, 23 after entry; `Queue_Count`=0.
- In `q_Run` with `In_Dirn`=00, press R then D at counter 1 and 3. Required: `Queue_Count` reaches 2; at the next `SCEN` `In_Dirn`=11; at the following `SCEN` `In_Dirn`=01; `Turn_Dropped` never pulses.
- With `In_Dirn`=00 and the queue empty, press D. Required: `Turn_Dropped` pulses once and `Queue_Count`=0. Then press U. Required: no pulse and no push.
- With the queue holding {10, 00}, press R at counter 2. Required: dropped with `Turn_Dropped`. Repeat the press at counter 6 (pop cycle). Required: accepted and `Queue_Count` stays 2.
- Raise U and L in the same cycle in `q_I`. Required: `In_Dirn`=00 next cycle; `SCEN` stays 0 throughout `q_I`.
- Assert `Reset`=0 at counter 5 with the queue non-empty. Required: next cycle `In_Dirn`=00, `Queue_Count`=0, `SCEN`=0, counter=0. Assert `q_Lose`. Required: presses ignored and `SCEN` stays 0.
